ase_umsg_scheduler: RTL
=======================

Name: ase_umsg_scheduler

Overview:
- Per-AFU UMsg controller for the ASE Rx0 response path.
- Accepts UMsg commands, each carrying a slot id, a hint flag and 512-bit data.
- Sequences each slot through a hint/data delay state machine and round-robin arbitrates ready slots onto one output stage feeding the Rx0 mux.
- Emits a UMsgHdr_t-format header (resp_type = ASE_UMSG) plus data.

Parameters:
- NUM_UMSG, 8, number of UMsg slots per AFU (1..64).
- TIMER_W, 6, delay timer width (matches UMSG_DELAY_TIMER_LOG2).
- HINT_DELAY, 8, hint wait count (< 2**TIMER_W).
- DATA_DELAY, 4, data wait count (< 2**TIMER_W).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command strobe, accepted every cycle (no backpressure).
- cmd_id  in  $clog2(NUM_UMSG)  target slot.
- cmd_hint  in  1  1 = send a hint message before the data message.
- cmd_data  in  512  UMsg payload.
- umsg_valid  out  1  output message valid.
- umsg_ready  in  1  Rx0 mux accepts the message when umsg_valid & umsg_ready.
- umsg_hdr  out  28  UMsgHdr_t layout.
- umsg_data  out  512  payload; all zero for hint messages.
- slot_busy  out  NUM_UMSG  bit i = 1 when slot i is not Idle.

Behaviour:
- Reset (async assert, sync release):
  - All slots Idle, timers 0, slot data 0.
  - umsg_valid = 0, umsg_hdr = 0, umsg_data = 0, slot_busy = 0.
  - RR pointer = NUM_UMSG-1, so slot 0 has first priority.
  - Reset mid-operation drops all pending and in-flight messages.
- Slot states: Idle, HintWait, SendHint, DataWait, SendData.
- Command to an Idle slot:
  - Data is latched.
  - cmd_hint = 1: go to HintWait, timer = HINT_DELAY.
  - cmd_hint = 0: go to DataWait, timer = DATA_DELAY.
- HintWait / DataWait:
  - timer == 0: advance to SendHint / SendData respectively.
  - Otherwise decrement. Each wait therefore lasts DELAY+1 cycles.
- SendHint on launch: go to DataWait, timer = DATA_DELAY.
- SendData on launch: go to Idle.
- Command to a non-Idle slot (coalescing):
  - HintWait / SendHint: data overwritten, state and timer unchanged.
  - DataWait / SendData: data overwritten, state forced to DataWait, timer = DATA_DELAY.
  - Same cycle as the slot's SendData launch: the launched message carries the old data; the slot goes to DataWait with the new data, so a second message follows.
  - cmd_hint is ignored for non-Idle slots.
- Output stage:
  - Load condition: output empty (!umsg_valid) or being accepted (umsg_valid & umsg_ready).
  - On load, select the first slot in SendHint/SendData searching from pointer+1 with wrap-around. The pointer is updated to the winner.
  - umsg_valid = 1 on load; cleared on accept when no winner exists that cycle.
  - Accept and load in the same cycle give back-to-back messages with no bubble.
  - umsg_valid, umsg_hdr and umsg_data stay stable while umsg_valid & !umsg_ready.
- Header encoding:
  - [27:20] = 0
  - [19:16] = 4'h6 (ASE_UMSG)
  - [15] = 1 for hint, 0 for data
  - [14:6] = 0
  - [5:0] = slot id, zero-extended
- Latency, idle system, no-hint command sampled at edge 0: umsg_valid asserts DATA_DELAY+3 cycles later.

Test Plan:
1. Reset, DATA_DELAY=4; cmd id=2, hint=0, data=512'hA5.. at cycle 0, umsg_ready=1 -> umsg_valid only in cycle 7, hdr=28'h0060002, data=A5.., slot_busy[2] clears after launch.
2. cmd id=1, hint=1, HINT_DELAY=8, DATA_DELAY=4 -> hint message (hdr=28'h0068001, data=0) at cycle 11, then data message (hdr=28'h0060001) at cycle 17.
3. Commands to slots 0, 3, 5 in the same-aligned cycle, umsg_ready=1 -> messages in order 0, 3, 5 on consecutive cycles. Repeat with pointer=3 -> order 5, 0, 3.
4. Hold umsg_ready=0 for 10 cycles while slot 4 is pending -> valid/hdr/data stay stable; slot 6 ready meanwhile is launched the cycle after acceptance.
5. Slot 2 in DataWait with timer=1 receives cmd data=B -> timer reloads to 4, exactly one data message carrying B. Cmd coinciding with the SendData launch -> two messages: old data, then new.
6. Assert rst_n=0 while umsg_valid=1 and three slots are busy -> umsg_valid=0 and slot_busy=0 immediately (asynchronous). No messages after release without new commands.

Source files
------------

// File: rtl/ase_umsg_scheduler.sv
// ase_umsg_scheduler: per-slot UMsg hint/data delay sequencing with round-robin launch onto one Rx0 output stage
module ase_umsg_scheduler #(
  parameter int NUM_UMSG   = 8,
  parameter int TIMER_W    = 6,
  parameter int HINT_DELAY = 8,
  parameter int DATA_DELAY = 4,
  localparam int IW = (NUM_UMSG > 1) ? $clog2(NUM_UMSG) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  input  logic [IW-1:0]       cmd_id,
  input  logic                cmd_hint,
  input  logic [511:0]        cmd_data,
  output logic                umsg_valid,
  input  logic                umsg_ready,
  output logic [27:0]         umsg_hdr,
  output logic [511:0]        umsg_data,
  output logic [NUM_UMSG-1:0] slot_busy
);
  typedef enum logic [2:0] {IDLE, HINT_WAIT, SEND_HINT, DATA_WAIT, SEND_DATA} slot_e;

  localparam logic [TIMER_W-1:0] HD = TIMER_W'(HINT_DELAY);
  localparam logic [TIMER_W-1:0] DD = TIMER_W'(DATA_DELAY);

  slot_e              state_q [NUM_UMSG];
  slot_e              state_d [NUM_UMSG];
  logic [TIMER_W-1:0] timer_q [NUM_UMSG];
  logic [TIMER_W-1:0] timer_d [NUM_UMSG];
  logic [511:0]       sdata_q [NUM_UMSG];
  logic [511:0]       sdata_d [NUM_UMSG];
  logic               cv_q, ch_q;
  logic [IW-1:0]      cid_q;
  logic [511:0]       cd_q;
  logic [IW-1:0]      ptr_q, ptr_d, win, idx;
  logic               found, load, launch, win_hint;
  logic               valid_q, valid_d;
  logic [27:0]        hdr_q, hdr_d;
  logic [511:0]       data_q, data_d;

  // Round-robin search for the first launchable slot after the pointer
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < NUM_UMSG; k++) begin
      idx = IW'((int'(ptr_q) + 1 + k) % NUM_UMSG);
      if (!found && (state_q[idx] == SEND_HINT || state_q[idx] == SEND_DATA)) begin
        found = 1'b1;
        win = idx;
      end
    end
  end

  // Slot sequencing: timer countdown, launch retirement, then command coalescing on top
  always_comb begin
    load = !valid_q || umsg_ready;
    launch = load && found;
    win_hint = state_q[win] == SEND_HINT;
    for (int i = 0; i < NUM_UMSG; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      sdata_d[i] = sdata_q[i];
      if (state_q[i] == HINT_WAIT || state_q[i] == DATA_WAIT) begin
        state_d[i] = timer_q[i] != '0 ? state_q[i] : state_q[i] == HINT_WAIT ? SEND_HINT : SEND_DATA;
        timer_d[i] = timer_q[i] != '0 ? timer_q[i] - 1'b1 : timer_q[i];
      end
      if (launch && win == IW'(i)) begin
        state_d[i] = win_hint ? DATA_WAIT : IDLE;
        timer_d[i] = win_hint ? DD : timer_q[i];
      end
      if (cv_q && cid_q == IW'(i)) begin
        sdata_d[i] = cd_q;
        if (state_q[i] == IDLE) begin
          state_d[i] = ch_q ? HINT_WAIT : DATA_WAIT;
          timer_d[i] = ch_q ? HD : DD;
        end else if (state_q[i] == DATA_WAIT || state_q[i] == SEND_DATA) begin
          state_d[i] = DATA_WAIT;
          timer_d[i] = DD;
        end
      end
    end
  end

  // Output stage loads the winner when empty or being accepted, otherwise holds
  always_comb begin
    ptr_d = launch ? win : ptr_q;
    valid_d = load ? found : valid_q;
    hdr_d = launch ? {8'h00, 4'h6, win_hint, 9'h000, 6'(win)} : hdr_q;
    data_d = launch ? (win_hint ? '0 : sdata_q[win]) : data_q;
  end

  // Busy flags straight from slot states
  always_comb begin
    for (int i = 0; i < NUM_UMSG; i++) slot_busy[i] = state_q[i] != IDLE;
  end

  // Command capture, slot state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv_q <= 1'b0;
      ch_q <= 1'b0;
      cid_q <= '0;
      cd_q <= '0;
      for (int i = 0; i < NUM_UMSG; i++) begin
        state_q[i] <= IDLE;
        timer_q[i] <= '0;
        sdata_q[i] <= '0;
      end
      ptr_q <= IW'(NUM_UMSG - 1);
      valid_q <= 1'b0;
      hdr_q <= '0;
      data_q <= '0;
    end else begin
      cv_q <= cmd_valid;
      ch_q <= cmd_hint;
      cid_q <= cmd_id;
      cd_q <= cmd_data;
      for (int i = 0; i < NUM_UMSG; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
        sdata_q[i] <= sdata_d[i];
      end
      ptr_q <= ptr_d;
      valid_q <= valid_d;
      hdr_q <= hdr_d;
      data_q <= data_d;
    end
  end

  assign umsg_valid = valid_q;
  assign umsg_hdr = hdr_q;
  assign umsg_data = data_q;
endmodule
